// File: rtl/pic_prio_ctrl_if.sv
// ---------------------------------------------------------------------------
// pic_prio_ctrl_if
// Bundles every signal of the priority interrupt controller except the
// clock and reset.
//   master : the CPU / system side. Drives the request lines, mode controls,
//            mask writes, EOI commands and INTA pulses, and reads back the
//            interrupt output, the vector and the IRR/ISR/IMR registers.
//   slave  : the controller itself.
// Signals:
//   irq[NIRQ]             interrupt request lines, bit 0 highest at reset
//   ltim                  1 = level-triggered, 0 = edge-triggered
//   aeoi                  automatic end-of-interrupt on the second INTA
//   rotate                1 = rotating priority, 0 = fixed priority
//   vec_base[VECW-IDW]    upper bits of the issued vector
//   imr_wr / imr_data     mask register write
//   eoi_req / eoi_specific / eoi_level   end-of-interrupt command
//   inta                  acknowledge strobe, one cycle per pulse
//   int_out               interrupt request to the CPU
//   vec / vec_valid       vector {vec_base, id} and its one-cycle qualifier
//   irr / isr / imr       register readback
// ---------------------------------------------------------------------------
interface pic_prio_ctrl_if #(
   parameter int NIRQ = 8,
   parameter int VECW = 8
);
   localparam int IDW = $clog2(NIRQ);

   logic [NIRQ-1:0]     irq;
   logic                ltim;
   logic                aeoi;
   logic                rotate;
   logic [VECW-IDW-1:0] vec_base;
   logic                imr_wr;
   logic [NIRQ-1:0]     imr_data;
   logic                eoi_req;
   logic                eoi_specific;
   logic [IDW-1:0]      eoi_level;
   logic                inta;
   logic                int_out;
   logic [VECW-1:0]     vec;
   logic                vec_valid;
   logic [NIRQ-1:0]     irr;
   logic [NIRQ-1:0]     isr;
   logic [NIRQ-1:0]     imr;

   modport master (
      output irq, ltim, aeoi, rotate, vec_base, imr_wr, imr_data,
             eoi_req, eoi_specific, eoi_level, inta,
      input  int_out, vec, vec_valid, irr, isr, imr
   );

   modport slave (
      input  irq, ltim, aeoi, rotate, vec_base, imr_wr, imr_data,
             eoi_req, eoi_specific, eoi_level, inta,
      output int_out, vec, vec_valid, irr, isr, imr
   );
endinterface

// File: rtl/pic_prio_ctrl.sv
// ---------------------------------------------------------------------------
// pic_prio_ctrl
// 8259-style priority interrupt controller. Requests are captured in IRR
// (edge or level mode), filtered by IMR, and the highest-priority candidate
// that outranks everything already in service (ISR) raises int_out. The CPU
// answers with two INTA pulses: the first accepts the winner into ISR, the
// second issues the vector {vec_base, id}. Priority is fixed (level 0
// highest) or rotating, where the last level cleared by an EOI becomes the
// lowest.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high, clears all state
//   bus    pic_prio_ctrl_if.slave, see the interface file for signal list
// ---------------------------------------------------------------------------
module pic_prio_ctrl #(
   parameter int NIRQ = 8,
   parameter int VECW = 8
) (
   input logic            clk,
   input logic            reset,
   pic_prio_ctrl_if.slave bus
);
   localparam int             IDW      = $clog2(NIRQ);
   localparam logic [IDW:0]   RANK_N   = (IDW+1)'(NIRQ);
   localparam logic [IDW:0]   RANK_NM1 = (IDW+1)'(NIRQ - 1);
   localparam logic [IDW-1:0] SPUR_ID  = IDW'(NIRQ - 1);
   localparam logic [IDW-1:0] LP_RESET = IDW'(NIRQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK1
   } state_e;

   state_e          state_q, state_d;
   logic [NIRQ-1:0] irq_q, irq_d;
   logic [NIRQ-1:0] irr_q, irr_d;
   logic [NIRQ-1:0] isr_q, isr_d;
   logic [NIRQ-1:0] imr_q, imr_d;
   logic [IDW-1:0]  lp_q, lp_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            spur_q, spur_d;
   logic            int_out_q, int_out_d;
   logic            vec_valid_q, vec_valid_d;
   logic [VECW-1:0] vec_q, vec_d;

   logic [NIRQ-1:0] cand;
   logic [IDW:0]    cur_rank;
   logic [IDW:0]    win_rank;
   logic [IDW-1:0]  win_id;
   logic            win_valid;
   logic [IDW:0]    isr_top_rank;
   logic [IDW-1:0]  isr_top_id;
   logic            isr_any;

   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] ack_set;
   logic [NIRQ-1:0] ack_irr_clr;
   logic [NIRQ-1:0] eoi_clr;
   logic [NIRQ-1:0] aeoi_clr;
   logic            eoi_hit;
   logic [IDW-1:0]  eoi_lvl;
   logic            aeoi_hit;

   // Rank 0 is the highest priority. In rotating mode the level just after
   // lp gets rank 0, so rank = (lvl - lp - 1) mod NIRQ; the +NIRQ keeps the
   // intermediate value non-negative and fits in IDW+1 bits for NIRQ<=2^IDW.
   function automatic logic [IDW:0] rank_of(input logic [IDW-1:0] lvl,
                                            input logic [IDW-1:0] lp,
                                            input logic           rot);
      logic [IDW:0] r;
      if (rot) begin
         r = {1'b0, lvl} + RANK_NM1 - {1'b0, lp};
         if (r >= RANK_N) begin
            r = r - RANK_N;
         end
      end else begin
         r = {1'b0, lvl};
      end
      return r;
   endfunction

   // Priority resolution: find the best unmasked request and the best
   // in-service level. A request only wins if it strictly outranks every
   // in-service level, which gives the fully nested behaviour.
   always_comb begin
      cand         = irr_q & ~imr_q;
      cur_rank     = '0;
      win_rank     = RANK_N;
      win_id       = '0;
      isr_top_rank = RANK_N;
      isr_top_id   = '0;
      for (int i = 0; i < NIRQ; i++) begin
         cur_rank = rank_of(IDW'(i), lp_q, bus.rotate);
         if (isr_q[i] && (cur_rank < isr_top_rank)) begin
            isr_top_rank = cur_rank;
            isr_top_id   = IDW'(i);
         end
         if (cand[i] && (cur_rank < win_rank)) begin
            win_rank = cur_rank;
            win_id   = IDW'(i);
         end
      end
      isr_any   = |isr_q;
      win_valid = (win_rank < isr_top_rank);
   end

   // Acknowledge sequence and EOI handling. The first INTA latches the
   // winner seen in that same cycle; if the request vanished or got masked
   // meanwhile, the lowest level is reported as a spurious id and nothing in
   // IRR/ISR is touched. ISR set has priority over any EOI clear of the same
   // bit because the set mask is OR-ed in after the clears.
   always_comb begin
      state_d     = state_q;
      int_out_d   = int_out_q;
      vec_d       = vec_q;
      vec_valid_d = 1'b0;
      id_d        = id_q;
      spur_d      = spur_q;
      ack_set     = '0;
      ack_irr_clr = '0;
      aeoi_clr    = '0;
      aeoi_hit    = 1'b0;
      eoi_clr     = '0;
      eoi_hit     = 1'b0;
      eoi_lvl     = '0;

      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d   = REQ;
               int_out_d = 1'b1;
            end
         end
         REQ: begin
            if (bus.inta) begin
               int_out_d = 1'b0;
               state_d   = ACK1;
               if (win_valid) begin
                  id_d            = win_id;
                  spur_d          = 1'b0;
                  ack_set[win_id] = 1'b1;
                  if (!bus.ltim) begin
                     ack_irr_clr[win_id] = 1'b1;
                  end
               end else begin
                  id_d   = SPUR_ID;
                  spur_d = 1'b1;
               end
            end
         end
         ACK1: begin
            if (bus.inta) begin
               vec_d       = {bus.vec_base, id_q};
               vec_valid_d = 1'b1;
               state_d     = IDLE;
               if (bus.aeoi && !spur_q) begin
                  aeoi_clr[id_q] = 1'b1;
                  aeoi_hit       = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (bus.eoi_req) begin
         if (bus.eoi_specific) begin
            if (({1'b0, bus.eoi_level} < RANK_N) && isr_q[bus.eoi_level]) begin
               eoi_clr[bus.eoi_level] = 1'b1;
               eoi_hit                = 1'b1;
               eoi_lvl                = bus.eoi_level;
            end
         end else if (isr_any) begin
            eoi_clr[isr_top_id] = 1'b1;
            eoi_hit             = 1'b1;
            eoi_lvl             = isr_top_id;
         end
      end
   end

   // Register next-state values. A fresh edge on a line that is being
   // accepted in the same cycle keeps the new request pending.
   always_comb begin
      rise  = bus.irq & ~irq_q;
      irq_d = bus.irq;
      if (bus.ltim) begin
         irr_d = bus.irq;
      end else begin
         irr_d = (irr_q & ~ack_irr_clr) | rise;
      end
      isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | ack_set;
      imr_d = bus.imr_wr ? bus.imr_data : imr_q;
      lp_d  = lp_q;
      if (bus.rotate) begin
         if (eoi_hit) begin
            lp_d = eoi_lvl;
         end
         if (aeoi_hit) begin
            lp_d = id_q;
         end
      end
   end

   // All controller state, cleared asynchronously by reset so that a
   // handshake in progress is abandoned immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         irq_q       <= '0;
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= '0;
         lp_q        <= LP_RESET;
         id_q        <= '0;
         spur_q      <= 1'b0;
         int_out_q   <= 1'b0;
         vec_valid_q <= 1'b0;
         vec_q       <= '0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         lp_q        <= lp_d;
         id_q        <= id_d;
         spur_q      <= spur_d;
         int_out_q   <= int_out_d;
         vec_valid_q <= vec_valid_d;
         vec_q       <= vec_d;
      end
   end

   assign bus.int_out   = int_out_q;
   assign bus.vec       = vec_q;
   assign bus.vec_valid = vec_valid_q;
   assign bus.irr       = irr_q;
   assign bus.isr       = isr_q;
   assign bus.imr       = imr_q;
endmodule

// File: tb/tb_pic_prio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pic_prio_ctrl
// Drives an 8-line controller through directed handshakes and random
// traffic, comparing every cycle against a behavioural model that walks the
// priority order position by position. A 16-line instance covers the wider
// id field and specific EOI.
// ---------------------------------------------------------------------------
module tb_pic_prio_ctrl;
   localparam int N  = 8;
   localparam int VW = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   // Model state for the 8-line instance.
   logic [N-1:0]  m_irr, m_isr, m_imr, m_irq_prev;
   int            m_lp, m_phase, m_id;
   logic          m_int, m_vv, m_spur;
   logic [VW-1:0] m_vec;

   pic_prio_ctrl_if #(.NIRQ(8),  .VECW(8)) bus   ();
   pic_prio_ctrl_if #(.NIRQ(16), .VECW(8)) bus16 ();

   pic_prio_ctrl #(.NIRQ(8),  .VECW(8)) dut   (.clk(clk), .reset(reset), .bus(bus));
   pic_prio_ctrl #(.NIRQ(16), .VECW(8)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Level occupying priority position k (0 = highest).
   function automatic int level_at(input int k);
      if (bus.rotate) return (m_lp + 1 + k) % N;
      return k;
   endfunction

   task automatic modelReset();
      m_irr = '0; m_isr = '0; m_imr = '0; m_irq_prev = '0;
      m_lp = N - 1; m_phase = 0; m_id = 0;
      m_int = 1'b0; m_vv = 1'b0; m_spur = 1'b0; m_vec = '0;
   endtask

   // One clock edge of the reference behaviour, using the inputs held
   // across that edge and the model state from before it.
   task automatic modelStep();
      int isr_pos, win, lvl, eoi_lvl, n_phase, n_id, n_lp;
      logic [N-1:0] set_m, clr_m, irr_clr, rise;
      bit eoi_hit, aeoi_hit;
      logic n_int, n_vv, n_spur;
      logic [VW-1:0] n_vec;

      isr_pos = N;
      for (int k = N - 1; k >= 0; k--) if (m_isr[level_at(k)]) isr_pos = k;
      win = -1;
      for (int k = N - 1; k >= 0; k--) begin
         lvl = level_at(k);
         if (k < isr_pos && m_irr[lvl] && !m_imr[lvl]) win = lvl;
      end

      set_m = '0; clr_m = '0; irr_clr = '0; eoi_hit = 0; aeoi_hit = 0; eoi_lvl = 0;
      n_phase = m_phase; n_id = m_id; n_int = m_int; n_vv = 1'b0; n_spur = m_spur; n_vec = m_vec;

      if (m_phase == 0) begin
         if (win >= 0) begin n_phase = 1; n_int = 1'b1; end
      end else if (m_phase == 1) begin
         if (bus.inta) begin
            n_int = 1'b0; n_phase = 2;
            if (win >= 0) begin
               n_id = win; n_spur = 1'b0; set_m[win] = 1'b1;
               if (!bus.ltim) irr_clr[win] = 1'b1;
            end else begin
               n_id = N - 1; n_spur = 1'b1;
            end
         end
      end else begin
         if (bus.inta) begin
            n_vv = 1'b1; n_vec = {bus.vec_base, m_id[2:0]}; n_phase = 0;
            if (bus.aeoi && !m_spur) begin clr_m[m_id] = 1'b1; aeoi_hit = 1; end
         end
      end

      if (bus.eoi_req) begin
         if (bus.eoi_specific) begin
            if (m_isr[bus.eoi_level]) begin
               clr_m[bus.eoi_level] = 1'b1; eoi_hit = 1; eoi_lvl = int'(bus.eoi_level);
            end
         end else if (isr_pos < N) begin
            eoi_lvl = level_at(isr_pos); clr_m[eoi_lvl] = 1'b1; eoi_hit = 1;
         end
      end

      n_lp = m_lp;
      if (bus.rotate && eoi_hit) n_lp = eoi_lvl;
      if (bus.rotate && aeoi_hit) n_lp = m_id;

      rise = bus.irq & ~m_irq_prev;
      m_irr = bus.ltim ? bus.irq : ((m_irr & ~irr_clr) | rise);
      m_isr = (m_isr & ~clr_m) | set_m;
      if (bus.imr_wr) m_imr = bus.imr_data;
      m_irq_prev = bus.irq;
      m_lp = n_lp; m_phase = n_phase; m_id = n_id;
      m_int = n_int; m_vv = n_vv; m_spur = n_spur; m_vec = n_vec;
   endtask

   task automatic checkAll();
      checkOutput("int_out", bus.int_out, m_int);
      checkOutput("vec_valid", bus.vec_valid, m_vv);
      checkOutput("vec", bus.vec, m_vec);
      checkOutput("irr", bus.irr, m_irr);
      checkOutput("isr", bus.isr, m_isr);
      checkOutput("imr", bus.imr, m_imr);
   endtask

   // Inputs are set on the falling edge; one rising edge is applied, the
   // model follows it, outputs are compared, and strobes drop again.
   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
      @(negedge clk);
      bus.inta = 1'b0; bus.eoi_req = 1'b0; bus.imr_wr = 1'b0;
   endtask

   task automatic setIdleInputs();
      bus.irq = '0; bus.ltim = 1'b0; bus.aeoi = 1'b0; bus.rotate = 1'b0;
      bus.vec_base = 5'h14; bus.imr_wr = 1'b0; bus.imr_data = '0;
      bus.eoi_req = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = '0; bus.inta = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      setIdleInputs();
      modelReset();
      #1;
      checkOutput("rst_int_out", bus.int_out, 0);
      checkOutput("rst_vec_valid", bus.vec_valid, 0);
      checkOutput("rst_vec", bus.vec, 0);
      checkOutput("rst_irr", bus.irr, 0);
      checkOutput("rst_isr", bus.isr, 0);
      checkOutput("rst_imr", bus.imr, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step16();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      setIdleInputs();
      bus16.irq = '0; bus16.ltim = 1'b0; bus16.aeoi = 1'b0; bus16.rotate = 1'b0;
      bus16.vec_base = 4'h9; bus16.imr_wr = 1'b0; bus16.imr_data = '0;
      bus16.eoi_req = 1'b0; bus16.eoi_specific = 1'b0; bus16.eoi_level = '0; bus16.inta = 1'b0;
      doReset();

      // Edge request on line 3, full two-pulse acknowledge.
      bus.irq = 8'h08;
      applyStimulus();
      checkOutput("e34_irr", bus.irr, 8'h08);
      checkOutput("e34_int_early", bus.int_out, 0);
      applyStimulus();
      checkOutput("e34_int", bus.int_out, 1);
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e34_isr", bus.isr, 8'h08);
      checkOutput("e34_irr_clr", bus.irr, 8'h00);
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e34_vec", bus.vec, 8'hA3);
      checkOutput("e34_vv", bus.vec_valid, 1);
      applyStimulus();
      checkOutput("e34_vv_pulse", bus.vec_valid, 0);
      checkOutput("e34_vec_hold", bus.vec, 8'hA3);
      bus.irq = '0; bus.eoi_req = 1'b1; applyStimulus();

      // Two simultaneous requests, nesting blocks the lower one.
      bus.irq = 8'h24; applyStimulus(); applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e35_vec_id2", bus.vec, 8'hA2);
      applyStimulus();
      checkOutput("e35_int_blocked", bus.int_out, 0);
      checkOutput("e35_irr_pend", bus.irr, 8'h20);
      bus.eoi_req = 1'b1; applyStimulus();
      checkOutput("e35_isr_eoi", bus.isr, 8'h00);
      applyStimulus();
      checkOutput("e35_int_again", bus.int_out, 1);
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e35_vec_id5", bus.vec, 8'hA5);
      bus.irq = '0; bus.eoi_req = 1'b1; applyStimulus();

      // Rotating priority: after servicing 0, level 7 outranks level 0.
      bus.rotate = 1'b1;
      bus.irq = 8'h01; applyStimulus(); applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      bus.irq = '0; bus.eoi_req = 1'b1; applyStimulus();
      bus.irq = 8'h81; applyStimulus(); applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e36_rot_id7", bus.vec, 8'hA7);
      bus.eoi_req = 1'b1; applyStimulus();
      applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e36_rot_id0", bus.vec, 8'hA0);
      bus.irq = '0; bus.eoi_req = 1'b1; bus.rotate = 1'b0; applyStimulus();

      // Level mode: request drops before the first INTA -> spurious id.
      bus.ltim = 1'b1;
      bus.irq = 8'h10; applyStimulus(); applyStimulus();
      bus.irq = '0; applyStimulus();
      checkOutput("e37_int_held", bus.int_out, 1);
      bus.inta = 1'b1; applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e37_spur_vec", bus.vec, 8'hA7);
      checkOutput("e37_isr", bus.isr, 8'h00);
      bus.ltim = 1'b0; applyStimulus();

      // Automatic EOI, then reset in the middle of a handshake.
      bus.aeoi = 1'b1;
      bus.irq = 8'h02; applyStimulus(); applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e38_isr_set", bus.isr, 8'h02);
      bus.inta = 1'b1; applyStimulus();
      checkOutput("e38_aeoi_vv", bus.vec_valid, 1);
      checkOutput("e38_aeoi_isr", bus.isr, 8'h00);
      bus.irq = '0; applyStimulus();
      bus.irq = 8'h02; applyStimulus(); applyStimulus();
      bus.inta = 1'b1; applyStimulus();
      doReset();
      for (int c = 0; c < 3; c++) begin
         bus.inta = 1'b1; applyStimulus();
         checkOutput("e38_no_vec", bus.vec_valid, 0);
      end

      // Random traffic against the model, three mode mixes.
      for (int seg = 0; seg < 3; seg++) begin
         doReset();
         bus.ltim = 1'($urandom_range(0, 1));
         bus.aeoi = 1'($urandom_range(0, 1));
         bus.rotate = 1'($urandom_range(0, 1));
         bus.vec_base = 5'($urandom);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               int b;
               b = $urandom_range(0, N - 1);
               bus.irq[b] = ~bus.irq[b];
            end
            bus.inta = ($urandom_range(0, 2) == 0);
            bus.eoi_req = ($urandom_range(0, 7) == 0);
            bus.eoi_specific = 1'($urandom_range(0, 1));
            bus.eoi_level = 3'($urandom);
            bus.imr_wr = ($urandom_range(0, 15) == 0);
            bus.imr_data = 8'($urandom & $urandom);
            if ($urandom_range(0, 49) == 0) bus.rotate = ~bus.rotate;
            applyStimulus();
         end
      end

      // 16-line instance: id 12 with a 4-bit vector base, specific EOI.
      @(negedge clk);
      bus16.irq = 16'h1000;
      step16();
      checkOutput("w16_irr", bus16.irr, 16'h1000);
      step16();
      checkOutput("w16_int", bus16.int_out, 1);
      @(negedge clk); bus16.inta = 1'b1;
      step16();
      checkOutput("w16_isr", bus16.isr, 16'h1000);
      step16();
      checkOutput("w16_vv", bus16.vec_valid, 1);
      checkOutput("w16_vec", bus16.vec, 8'h9C);
      @(negedge clk);
      bus16.inta = 1'b0; bus16.eoi_req = 1'b1; bus16.eoi_specific = 1'b1; bus16.eoi_level = 4'd12;
      step16();
      checkOutput("w16_eoi_isr", bus16.isr, 16'h0000);
      @(negedge clk);
      bus16.eoi_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/pic_prio_ctrl.md
PIC_PRIO_CTRL -- requirements
Module: pic_prio_ctrl

Interface
REQ-001 Parameter NIRQ, default 8, number of request lines; legal range 2..32.
REQ-002 Parameter VECW, default 8, vector width; IDW = clog2(NIRQ); VECW > IDW.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 irq  in  NIRQ  interrupt request lines; bit 0 is highest priority at reset.
REQ-006 ltim  in  1  1 = level-triggered, 0 = edge-triggered.
REQ-007 aeoi  in  1  automatic EOI at end of acknowledge.
REQ-008 rotate  in  1  1 = rotating priority, 0 = fixed priority.
REQ-009 vec_base  in  VECW-IDW  upper vector bits.
REQ-010 imr_wr  in  1  mask write strobe; imr_data  in  NIRQ  new mask.
REQ-011 eoi_req  in  1  EOI strobe; eoi_specific  in  1  specific/non-specific; eoi_level  in  IDW  target level.
REQ-012 inta  in  1  acknowledge strobe, one cycle per INTA pulse.
REQ-013 int_out  out  1  interrupt request to CPU, registered.
REQ-014 vec  out  VECW  vector {vec_base, id}; vec_valid  out  1  one-cycle qualifier.
REQ-015 irr  out  NIRQ, isr  out  NIRQ, imr  out  NIRQ  register readback.

Function
REQ-016 Edge mode: IRR[i] set on the edge where irq[i] is sampled 1 and the previous sample was 0; cleared only by acceptance of level i at the first INTA.
REQ-017 Level mode: IRR[i] equals irq[i] registered each cycle; acceptance does not clear it.
REQ-018 Candidates = IRR & ~IMR; winner = highest-priority candidate strictly higher than the highest-priority ISR bit (fully nested).
REQ-019 Fixed priority: level 0 highest, NIRQ-1 lowest.
REQ-020 Rotating priority: pointer lp (reset NIRQ-1) names the lowest level; priority order lp+1, lp+2, ... mod NIRQ; lp <= cleared level on every EOI (manual or automatic) while rotate=1.
REQ-021 FSM states IDLE, REQ, ACK1; reset state IDLE.
REQ-022 IDLE: winner exists -> REQ, int_out=1 from the next edge.
REQ-023 REQ: inta -> latch winner id, ISR[id]<=1, clear IRR[id] (edge mode), int_out<=0, -> ACK1; same-cycle winner used.
REQ-024 REQ with no winner at inta (masked/dropped): id = NIRQ-1 spurious, no ISR/IRR change, -> ACK1.
REQ-025 REQ, winner disappears without inta: int_out stays 1 until inta.
REQ-026 ACK1: next inta -> vec={vec_base,id}, vec_valid=1 one cycle, -> IDLE; if aeoi and non-spurious, ISR[id]<=0 same edge.
REQ-027 inta in IDLE ignored.
REQ-028 Non-specific EOI clears highest-priority set ISR bit; specific EOI clears ISR[eoi_level]; eoi_level >= NIRQ or empty ISR -> no effect.
REQ-029 EOI and ISR set on the same bit in one cycle: set wins; different bits: both apply.
REQ-030 imr_wr: IMR <= imr_data at that edge; masking affects new winners only, not ISR.
REQ-031 vec holds its last value when vec_valid=0.

Reset
REQ-032 On reset: IRR, ISR, IMR, irq sample = 0; lp = NIRQ-1; state IDLE; int_out=0, vec=0, vec_valid=0.
REQ-033 Reset mid-handshake abandons it; no vector issued after release.

Verification
REQ-034 NIRQ=8, edge, irq[3] 0->1 at edge k -> irr=0x08 after k, int_out=1 after k+1; two inta -> isr=0x08, irr=0, vec={vec_base,3'd3}, vec_valid one cycle.
REQ-035 irq[5] and irq[2] together -> vec id 2; while ISR[2] set, IRR[5] pending, int_out stays 0; non-specific EOI -> isr=0, int_out=1, next ack id 5.
REQ-036 rotate=1, service level 0 then EOI -> lp=0; irq[0] and irq[7] together -> id 1-first order gives id 7 before 0.
REQ-037 Level mode, irq[4] high then drop before first inta -> vec id 7 (spurious), isr unchanged at 0.
REQ-038 aeoi=1, ack irq[1] -> isr=0 at vec_valid cycle; reset asserted in ACK1 -> int_out=0, vec_valid never asserts, all registers 0.
REQ-039 NIRQ=16, VECW=8: irq[12] acked -> vec={vec_base[3:0],4'd12}; specific EOI eoi_level=12 -> isr=0.
